ex_operand_stage: RTL and testbench



---
 rtl/ex_operand_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX register stage that sits directly in front of the ALU. It decodes
// RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC), picks the operands
// from the register file or from the EX/MEM and MEM/WB forwarding paths, and
// registers alu_a / alu_b / alu_op / rd / rd_we / illegal behind a
// valid/ready handshake with one cycle of latency.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake (decode slot)
//   instr, pc                  instruction word and its address
//   rs1_data, rs2_data         register-file read data
//   flush                      squash held and incoming instruction
//   exm_we/exm_rd/exm_data     EX/MEM forwarding source
//   mwb_we/mwb_rd/mwb_data     MEM/WB forwarding source
//   out_valid / out_ready      downstream handshake (ALU/EX)
//   alu_a, alu_b, alu_op       ALU operands and operation
//   rd, rd_we, illegal         destination, writeback enable, illegal flag
//   perf_issued, perf_stall    only when EX_OPERAND_PERF_EN is defined
//
// Build option: define EX_OPERAND_PERF_EN to add the transfer and stall
// counters (PERF_W bits each, wrapping, unaffected by flush).
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            exm_we,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_we,
  input  logic [4:0]      mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
`ifdef EX_OPERAND_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_issued,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // funct7=0 map shared by OP and OP-IMM
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [3:0]      w_op;
  logic            w_legal;
  logic            w_capture;
  logic            w_transfer;

  logic            r_valid;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic            r_illegal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_u  = {instr[31:12], 12'b0};
  assign w_shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Held during reset so nothing is accepted while the stage is being cleared.
  assign in_ready   = rst_n & (~r_valid | out_ready);
  assign w_capture  = in_valid & in_ready;
  assign w_transfer = r_valid & out_ready;

  // rsN != 0 here, so a matching rd is implicitly non-zero; EX/MEM is younger
  // and therefore takes priority over MEM/WB.
  always_comb begin
    w_op1 = rs1_data;
    if (w_rs1 == 5'd0)                       w_op1 = '0;
    else if (exm_we && (exm_rd == w_rs1))    w_op1 = exm_data;
    else if (mwb_we && (mwb_rd == w_rs1))    w_op1 = mwb_data;
  end

  always_comb begin
    w_op2 = rs2_data;
    if (w_rs2 == 5'd0)                       w_op2 = '0;
    else if (exm_we && (exm_rd == w_rs2))    w_op2 = exm_data;
    else if (mwb_we && (mwb_rd == w_rs2))    w_op2 = mwb_data;
  end

  always_comb begin
    w_legal = 1'b0;
    w_a     = '0;
    w_b     = '0;
    w_op    = ALU_ADD;
    case (w_opcode)
      OPC_OP: begin
        w_a = w_op1;
        w_b = w_op2;
        if (w_funct7 == 7'h00) begin
          w_legal = 1'b1;
          w_op    = f3_to_op(w_funct3);
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd0) begin
          w_legal = 1'b1;
          w_op    = ALU_SUB;
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd5) begin
          w_legal = 1'b1;
          w_op    = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        w_a  = w_op1;
        w_b  = w_imm_i;
        w_op = f3_to_op(w_funct3);
        case (w_funct3)
          3'd1: begin
            w_b     = w_shamt;
            w_legal = (w_funct7 == 7'h00);
          end
          3'd5: begin
            w_b = w_shamt;
            if (w_funct7 == 7'h00) begin
              w_legal = 1'b1;
              w_op    = ALU_SRL;
            end else if (w_funct7 == 7'h20) begin
              w_legal = 1'b1;
              w_op    = ALU_SRA;
            end
          end
          default: w_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_b     = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_a     = pc;
        w_b     = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal instructions still issue, but as a harmless ADD of zeros.
    if (!w_legal) begin
      w_a  = '0;
      w_b  = '0;
      w_op = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ALU_ADD;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_alu_a   <= w_a;
      r_alu_b   <= w_b;
      r_alu_op  <= w_op;
      r_rd      <= instr[11:7];
      r_rd_we   <= w_legal & (instr[11:7] != 5'd0);
      r_illegal <= ~w_legal;
    end else if (w_transfer) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rd        = r_rd;
  assign rd_we     = r_rd_we;
  assign illegal   = r_illegal;

`ifdef EX_OPERAND_PERF_EN
  logic [PERF_W-1:0] r_perf_issued;
  logic [PERF_W-1:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_transfer)             r_perf_issued <= r_perf_issued + 1'b1;
      if (r_valid && !out_ready)  r_perf_stall  <= r_perf_stall + 1'b1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: hand-computed vectors covering reset,
// forwarding priority, immediates, hold/back-to-back issue, flush, illegal
// encodings and reset during hold.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        exm_we;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        mwb_we;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
`ifdef EX_OPERAND_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .PERF_W(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .exm_we    (exm_we),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_we    (mwb_we),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
`ifdef EX_OPERAND_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                     input logic mw, input logic [4:0] mr, input logic [31:0] md);
    exm_we = ew; exm_rd = er; exm_data = ed;
    mwb_we = mw; mwb_rd = mr; mwb_data = md;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] d,
                           input logic we, input logic ill);
    check({tag, ".valid"},   {31'b0, out_valid}, 32'd1);
    check({tag, ".a"},       alu_a, a);
    check({tag, ".b"},       alu_b, b);
    check({tag, ".op"},      {28'b0, alu_op}, {28'b0, op});
    check({tag, ".rd"},      {27'b0, rd}, {27'b0, d});
    check({tag, ".rd_we"},   {31'b0, rd_we}, {31'b0, we});
    check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
  endtask

  // Single issue with consumer ready: capture, then check registered outputs.
  task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] d,
                       input logic we, input logic ill);
    drive(i, p, r1, r2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_out(tag, a, b, op, d, we, ill);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset state
    tick();
    tick();
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.alu_a",     alu_a, 32'd0);
    check("rst.alu_b",     alu_b, 32'd0);
    check("rst.alu_op",    {28'b0, alu_op}, 32'd0);
    check("rst.rd",        {27'b0, rd}, 32'd0);
    check("rst.rd_we",     {31'b0, rd_we}, 32'd0);
    check("rst.illegal",   {31'b0, illegal}, 32'd0);
    check("rst.in_ready",  {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Hold, then back-to-back release
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd3);          // ADD x3,x1,x2
    in_valid = 1'b1;
    tick();
    check_out("add", 32'd5, 32'd3, 4'd0, 5'd3, 1'b1, 1'b0);
    drive(32'h402081B3, 32'h0, 32'd1234, 32'd3);       // SUB x3,x1,x2
    fwd(1'b1, 5'd1, 32'd10, 1'b1, 5'd1, 32'd99);
    for (int k = 0; k < 3; k++) begin
      check("hold.in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check_out("hold", 32'd5, 32'd3, 4'd0, 5'd3, 1'b1, 1'b0);
    end
`ifdef EX_OPERAND_PERF_EN
    check("hold.perf_stall",  perf_stall, 32'd3);
    check("hold.perf_issued", perf_issued, 32'd0);
`endif
    out_ready = 1'b1;
    #1;
    check("release.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check_out("sub_fwd", 32'd10, 32'd3, 4'd1, 5'd3, 1'b1, 1'b0);
`ifdef EX_OPERAND_PERF_EN
    check("b2b.perf_issued1", perf_issued, 32'd1);
`endif
    drive(32'hFFF00293, 32'h0, 32'h55, 32'h0);        // ADDI x5,x0,-1
    fwd(1'b1, 5'd0, 32'd7, 1'b0, 5'd0, 32'h0);
    tick();
    check_out("addi_neg", 32'd0, 32'hFFFF_FFFF, 4'd0, 5'd5, 1'b1, 1'b0);
`ifdef EX_OPERAND_PERF_EN
    check("b2b.perf_issued2", perf_issued, 32'd2);
`endif
    in_valid = 1'b0;
    tick();
    check("drain.out_valid", {31'b0, out_valid}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
    check("drain.perf_issued", perf_issued, 32'd3);
    check("drain.perf_stall",  perf_stall, 32'd3);
`endif

    // Directed decode vectors, consumer always ready
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue("auipc", 32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF,
          32'h100, 32'h12345000, 4'd0, 5'd1, 1'b1, 1'b0);
    issue("lui", 32'hABCDE3B7, 32'h200, 32'hDEAD, 32'hBEEF,
          32'h0, 32'hABCDE000, 4'd0, 5'd7, 1'b1, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h8000_0000);
    issue("srai_mwb", 32'h4040D313, 32'h0, 32'h1111, 32'h0,
          32'h8000_0000, 32'd4, 4'd7, 5'd6, 1'b1, 1'b0);
    fwd(1'b0, 5'd1, 32'h1234, 1'b1, 5'd2, 32'h0F);
    issue("xor_fwd", 32'h0020C433, 32'h0, 32'h11, 32'h22,
          32'h11, 32'h0F, 4'd5, 5'd8, 1'b1, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue("add_x0", 32'h00208033, 32'h0, 32'd7, 32'd8,
          32'd7, 32'd8, 4'd0, 5'd0, 1'b0, 1'b0);
    issue("load_ill", 32'h0000A203, 32'h0, 32'd7, 32'd8,
          32'd0, 32'd0, 4'd0, 5'd4, 1'b0, 1'b1);
    issue("slli_ill", 32'h40309313, 32'h0, 32'd7, 32'd8,
          32'd0, 32'd0, 4'd0, 5'd6, 1'b0, 1'b1);
    issue("op_f7_ill", 32'h402091B3, 32'h0, 32'd7, 32'd8,
          32'd0, 32'd0, 4'd0, 5'd3, 1'b0, 1'b1);
    issue("slli_ok", 32'h00309313, 32'h0, 32'd7, 32'd8,
          32'd7, 32'd3, 4'd2, 5'd6, 1'b1, 1'b0);

    // Flush while holding
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd3);
    in_valid = 1'b1;
    tick();
    check("flush_hold.pre", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hold.out_valid", {31'b0, out_valid}, 32'd0);

    // Flush while capturing
    out_ready = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_cap.out_valid", {31'b0, out_valid}, 32'd0);

    // Reset during hold
    out_ready = 1'b0;
    drive(32'h0020C433, 32'h0, 32'h11, 32'h22);        // XOR x8 -> nonzero fields
    in_valid = 1'b1;
    tick();
    check_out("rst_hold.pre", 32'h11, 32'h22, 4'd5, 5'd8, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_hold.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("rst_hold.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_hold.alu_a",     alu_a, 32'd0);
    check("rst_hold.alu_b",     alu_b, 32'd0);
    check("rst_hold.alu_op",    {28'b0, alu_op}, 32'd0);
    check("rst_hold.rd",        {27'b0, rd}, 32'd0);
    check("rst_hold.rd_we",     {31'b0, rd_we}, 32'd0);
    check("rst_hold.in_ready2", {31'b0, in_ready}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
    check("rst_hold.perf_stall", perf_stall, 32'd0);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    do_reset();
    tick();
    check("end.out_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
